mc_control_fsm: RTL

Multi-cycle MIPS main control unit: a Moore-style state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath select and write-enable, including the 3-bit ALU operand-B select consumed by the operand-B mux, and stalls on a memory-ready handshake.

---
 rtl/mc_pkg.sv | 67 ++++++
 rtl/mc_control_fsm_if.sv | 40 ++++
 rtl/mc_control_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: state codes,
// opcode/funct values and the datapath select encodings that the operand
// muxes decode.
package mc_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REX    = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_BNE    = 4'd10,
      S_IEX    = 4'd11,
      S_IWB    = 4'd12,
      S_JUMP   = 4'd13,
      S_HALT   = 4'd14
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Function codes (IR[5:0]) that need the shift operand routing
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;

   // Operand-A select
   localparam logic [1:0] SRCA_PC = 2'd0;
   localparam logic [1:0] SRCA_A  = 2'd1;
   localparam logic [1:0] SRCA_B  = 2'd2;

   // Operand-B select
   localparam logic [2:0] SRCB_B        = 3'd0;
   localparam logic [2:0] SRCB_FOUR     = 3'd1;
   localparam logic [2:0] SRCB_SEXT     = 3'd2;
   localparam logic [2:0] SRCB_SEXT_SH2 = 3'd3;
   localparam logic [2:0] SRCB_ZEXT     = 3'd4;
   localparam logic [2:0] SRCB_SHAMT    = 3'd5;

   // ALU operation
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   // PC source
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Shifts take the shamt field as operand B and rt (B reg) as operand A.
   function automatic logic is_shift(input logic [5:0] funct);
      return (funct == FN_SLL) || (funct == FN_SRL);
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the main control FSM (master) and the datapath (slave):
// instruction fields and memory handshake in, selects and strobes out.
interface mc_control_fsm_if;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;

   logic       pc_write;
   logic       pc_write_eq;
   logic       pc_write_ne;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [2:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       halted;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_op, pc_source, halted, state_dbg
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_op, pc_source, halted, state_dbg
   );

endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit. Moore FSM stepping each instruction
// through fetch/decode/execute/memory/write-back; outputs decode the state
// register, except the FETCH-cycle IR/PC loads which also wait on mem_ready.
module mc_control_fsm
   import mc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   mc_control_fsm_if.master   bus
);

   state_t state;
   state_t state_next;
   logic   run;   // low for the first edge after reset release, so IDLE lasts one cycle

   // State register and reset-release delay flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         run   <= 1'b0;
      end else begin
         state <= state_next;
         run   <= 1'b1;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:   if (run) state_next = S_FETCH;
         S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            unique case (bus.opcode)
               OP_LW, OP_SW:    state_next = S_MEMADR;
               OP_RTYPE:        state_next = S_REX;
               OP_BEQ:          state_next = S_BEQ;
               OP_BNE:          state_next = S_BNE;
               OP_ADDI, OP_ORI: state_next = S_IEX;
               OP_J:            state_next = S_JUMP;
               default:         state_next = S_HALT;
            endcase
         end
         S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.mem_ready) state_next = S_MEMWB;
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
         S_REX:    state_next = S_RWB;
         S_RWB:    state_next = S_FETCH;
         S_BEQ:    state_next = S_FETCH;
         S_BNE:    state_next = S_FETCH;
         S_IEX:    state_next = S_IWB;
         S_IWB:    state_next = S_FETCH;
         S_JUMP:   state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_HALT;
      endcase
   end

   // Output decode: everything defaults to 0, each state raises only its own controls
   always_comb begin
      bus.pc_write    = 1'b0;
      bus.pc_write_eq = 1'b0;
      bus.pc_write_ne = 1'b0;
      bus.iord        = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_dst     = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.reg_write   = 1'b0;
      bus.alu_src_a   = SRCA_PC;
      bus.alu_src_b   = SRCB_B;
      bus.alu_op      = ALU_ADD;
      bus.pc_source   = PCSRC_ALU;
      bus.halted      = 1'b0;
      bus.state_dbg   = state;
      unique case (state)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_a = SRCA_PC;
            bus.alu_src_b = SRCB_FOUR;
            bus.alu_op    = ALU_ADD;
            bus.pc_source = PCSRC_ALU;
            // IR and PC load only on the cycle the instruction word arrives
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alu_src_a = SRCA_PC;
            bus.alu_src_b = SRCB_SEXT_SH2;
         end
         S_MEMADR: begin
            bus.alu_src_a = SRCA_A;
            bus.alu_src_b = SRCB_SEXT;
            bus.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
         end
         S_MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            bus.reg_dst    = 1'b0;
         end
         S_MEMWR: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
         end
         S_REX: begin
            bus.alu_op = ALU_FUNCT;
            if (is_shift(bus.funct)) begin
               bus.alu_src_a = SRCA_B;
               bus.alu_src_b = SRCB_SHAMT;
            end else begin
               bus.alu_src_a = SRCA_A;
               bus.alu_src_b = SRCB_B;
            end
         end
         S_RWB: begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 1'b1;
            bus.mem_to_reg = 1'b0;
         end
         S_BEQ, S_BNE: begin
            bus.alu_src_a   = SRCA_A;
            bus.alu_src_b   = SRCB_B;
            bus.alu_op      = ALU_SUB;
            bus.pc_source   = PCSRC_ALUOUT;
            bus.pc_write_eq = (state == S_BEQ);
            bus.pc_write_ne = (state == S_BNE);
         end
         S_IEX: begin
            bus.alu_src_a = SRCA_A;
            if (bus.opcode == OP_ORI) begin
               bus.alu_src_b = SRCB_ZEXT;
               bus.alu_op    = ALU_OR;
            end else begin
               bus.alu_src_b = SRCB_SEXT;
               bus.alu_op    = ALU_ADD;
            end
         end
         S_IWB: begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
         end
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PCSRC_JUMP;
         end
         S_HALT: begin
            bus.halted = 1'b1;
         end
         default: begin
            bus.state_dbg = state;
         end
      endcase
   end

endmodule
